dlx_hazard_scoreboard: RTL and testbench

Parametrised successor to the DLX decode-stage stall/kill logic. It replaces the fixed "stall one slot after any load, kill one slot after a taken branch" rule with a per-register scoreboard. The scoreboard covers the integer and FP register files and handles configurable load latency, FP latency and branch delay-slot count. It sits beside the decode/control logic: decode presents one candidate instruction per cycle, and this block returns accept, stall and kill.

---
 rtl/dlx_hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_dlx_hazard_scoreboard.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_hazard_scoreboard.sv
// Per-register hazard scoreboard for the DLX decode stage: tracks integer/FP
// result latencies and taken-branch kill slots, returning accept/stall/kill.
module dlx_hazard_scoreboard #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned LOAD_LAT   = 2,
    parameter int unsigned FP_LAT     = 4,
    parameter int unsigned KILL_SLOTS = 1,
    localparam int unsigned RW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [RW-1:0]       issue_rs1,
    input  logic [RW-1:0]       issue_rs2,
    input  logic                issue_use_rs1,
    input  logic                issue_use_rs2,
    input  logic [1:0]          issue_src_fp,
    input  logic [RW-1:0]       issue_rd,
    input  logic                issue_rd_fp,
    input  logic                issue_wr,
    input  logic [1:0]          issue_lat,
    input  logic                branch_taken,
    output logic                issue_accept,
    output logic                stall,
    output logic                kill,
    output logic [NUM_REGS-1:0] busy_int,
    output logic [NUM_REGS-1:0] busy_fp
);

    localparam int unsigned CW = $clog2(FP_LAT) + 1;
    localparam int unsigned KW = (KILL_SLOTS > 0) ? $clog2(KILL_SLOTS + 1) : 1;

    logic [CW-1:0] r_cnt_int [NUM_REGS];
    logic [CW-1:0] r_cnt_fp  [NUM_REGS];
    logic [KW-1:0] r_kcnt;

    logic [CW-1:0] w_src1_cnt;
    logic [CW-1:0] w_src2_cnt;
    logic [CW-1:0] w_rd_cnt;
    logic [CW-1:0] w_new_lat;
    logic          w_raw;
    logic          w_waw;
    logic          w_kill;
    logic          w_stall;
    logic          w_accept;
    logic          w_set;

    // Hazard detection against the current scoreboard contents
    always_comb begin
        w_src1_cnt = issue_src_fp[0] ? r_cnt_fp[issue_rs1] : r_cnt_int[issue_rs1];
        w_src2_cnt = issue_src_fp[1] ? r_cnt_fp[issue_rs2] : r_cnt_int[issue_rs2];
        w_rd_cnt   = issue_rd_fp ? r_cnt_fp[issue_rd] : r_cnt_int[issue_rd];
        case (issue_lat)
            2'd0:    w_new_lat = '0;
            2'd1:    w_new_lat = CW'(LOAD_LAT - 1);
            default: w_new_lat = CW'(FP_LAT - 1);
        endcase
        w_raw    = (issue_use_rs1 && (w_src1_cnt != '0)) ||
                   (issue_use_rs2 && (w_src2_cnt != '0));
        w_waw    = issue_wr && (w_rd_cnt > w_new_lat);
        w_kill   = (r_kcnt != '0);
        w_stall  = issue_valid && !w_kill && (w_raw || w_waw);
        w_accept = issue_valid && !w_kill && !w_stall;
        w_set    = w_accept && issue_wr && (w_new_lat != '0);
    end

    // Countdown and kill-slot state; a new entry overrides that entry's decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_cnt_int[i] <= '0;
                r_cnt_fp[i]  <= '0;
            end
            r_kcnt <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (r_cnt_int[i] != '0) r_cnt_int[i] <= r_cnt_int[i] - CW'(1);
                if (r_cnt_fp[i]  != '0) r_cnt_fp[i]  <= r_cnt_fp[i]  - CW'(1);
            end
            if (w_set) begin
                if (issue_rd_fp)
                    r_cnt_fp[issue_rd] <= w_new_lat;
                else if (issue_rd != '0)
                    r_cnt_int[issue_rd] <= w_new_lat;
            end
            if (w_accept && branch_taken)
                r_kcnt <= KW'(KILL_SLOTS);
            else if (r_kcnt != '0)
                r_kcnt <= r_kcnt - KW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            busy_int[i] = |r_cnt_int[i];
            busy_fp[i]  = |r_cnt_fp[i];
        end
    end

    assign issue_accept = w_accept;
    assign stall        = w_stall;
    assign kill         = w_kill;

endmodule

// File: tb/tb_dlx_hazard_scoreboard.sv
// Scenario bench for dlx_hazard_scoreboard (KILL_SLOTS = 2, other defaults);
// expected outputs are queued with each stimulus row and compared per cycle.
module tb_dlx_hazard_scoreboard;

    localparam int unsigned NR = 32;
    localparam int unsigned RW = 5;

    typedef struct packed {
        logic          rst;
        logic          v;
        logic [RW-1:0] rs1;
        logic          u1;
        logic [RW-1:0] rs2;
        logic          u2;
        logic [1:0]    sfp;
        logic [RW-1:0] rd;
        logic          rdfp;
        logic          wr;
        logic [1:0]    lat;
        logic          br;
    } stim_t;

    typedef struct packed {
        logic          acc;
        logic          stl;
        logic          kil;
        logic [NR-1:0] bi;
        logic [NR-1:0] bf;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [RW-1:0] issue_rs1;
    logic [RW-1:0] issue_rs2;
    logic          issue_use_rs1;
    logic          issue_use_rs2;
    logic [1:0]    issue_src_fp;
    logic [RW-1:0] issue_rd;
    logic          issue_rd_fp;
    logic          issue_wr;
    logic [1:0]    issue_lat;
    logic          branch_taken;
    logic          issue_accept;
    logic          stall;
    logic          kill;
    logic [NR-1:0] busy_int;
    logic [NR-1:0] busy_fp;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t exp_q[$];

    dlx_hazard_scoreboard #(
        .NUM_REGS(NR), .LOAD_LAT(2), .FP_LAT(4), .KILL_SLOTS(2)
    ) dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_src_fp(issue_src_fp), .issue_rd(issue_rd),
        .issue_rd_fp(issue_rd_fp), .issue_wr(issue_wr),
        .issue_lat(issue_lat), .branch_taken(branch_taken),
        .issue_accept(issue_accept), .stall(stall), .kill(kill),
        .busy_int(busy_int), .busy_fp(busy_fp)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic v, input int rs1, input logic u1,
                                 input int rs2, input logic u2, input logic [1:0] sfp,
                                 input int rd, input logic rdfp, input logic wr,
                                 input logic [1:0] lat, input logic br);
        stim_t s;
        s.rst = 1'b0; s.v = v; s.rs1 = RW'(rs1); s.u1 = u1; s.rs2 = RW'(rs2);
        s.u2 = u2; s.sfp = sfp; s.rd = RW'(rd); s.rdfp = rdfp; s.wr = wr;
        s.lat = lat; s.br = br;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0);
    endfunction

    function automatic stim_t with_rst(input stim_t s);
        stim_t r = s;
        r.rst = 1'b1;
        return r;
    endfunction

    function automatic obs_t ob(input logic a, input logic s, input logic k,
                                input logic [NR-1:0] bi, input logic [NR-1:0] bf);
        return '{acc: a, stl: s, kil: k, bi: bi, bf: bf};
    endfunction

    function automatic obs_t sample();
        return '{acc: issue_accept, stl: stall, kil: kill, bi: busy_int, bf: busy_fp};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("acc=%b stall=%b kill=%b busy_int=%h busy_fp=%h",
                         o.acc, o.stl, o.kil, o.bi, o.bf);
    endfunction

    task automatic apply(input stim_t s);
        reset         = s.rst;
        issue_valid   = s.v;
        issue_rs1     = s.rs1;
        issue_rs2     = s.rs2;
        issue_use_rs1 = s.u1;
        issue_use_rs2 = s.u2;
        issue_src_fp  = s.sfp;
        issue_rd      = s.rd;
        issue_rd_fp   = s.rdfp;
        issue_wr      = s.wr;
        issue_lat     = s.lat;
        branch_taken  = s.br;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  got, want;
        apply(with_rst(mk(1, 5, 1, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0)));
        @(posedge clk); #1;
        s.push_back(with_rst(mk(1, 5, 1, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0))); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(mk(1, 5, 1, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0));           exp_q.push_back(ob(1, 0, 0, '0, '0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset cyc %0d: got %s want %s", k, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        obs_t  got, want;
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 3, 0, 1, 2'd1, 0)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(mk(1, 3, 1, 0, 0, 2'b00, 4, 0, 1, 2'd0, 0)); exp_q.push_back(ob(0, 1, 0, 32'h8, '0));
        s.push_back(mk(1, 3, 1, 0, 0, 2'b00, 4, 0, 1, 2'd0, 0)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(idle());                                     exp_q.push_back(ob(0, 0, 0, '0, '0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL load_use cyc %0d: got %s want %s", k, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fp_raw();
        stim_t s[$];
        obs_t  got, want;
        // f2 reader stalls three cycles
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2, 1, 1, 2'd2, 0)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(mk(1, 2, 1, 0, 0, 2'b01, 7, 0, 1, 2'd0, 0)); exp_q.push_back(ob(0, 1, 0, '0, 32'h4));
        s.push_back(mk(1, 2, 1, 0, 0, 2'b01, 7, 0, 1, 2'd0, 0)); exp_q.push_back(ob(0, 1, 0, '0, 32'h4));
        s.push_back(mk(1, 2, 1, 0, 0, 2'b01, 7, 0, 1, 2'd0, 0)); exp_q.push_back(ob(0, 1, 0, '0, 32'h4));
        s.push_back(mk(1, 2, 1, 0, 0, 2'b01, 7, 0, 1, 2'd0, 0)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        // integer r2 readers while f2 is busy
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2, 1, 1, 2'd3, 0)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(mk(1, 2, 1, 2, 1, 2'b00, 7, 0, 1, 2'd0, 0)); exp_q.push_back(ob(1, 0, 0, '0, 32'h4));
        s.push_back(mk(1, 2, 1, 2, 1, 2'b00, 8, 0, 1, 2'd0, 0)); exp_q.push_back(ob(1, 0, 0, '0, 32'h4));
        s.push_back(idle());                                     exp_q.push_back(ob(0, 0, 0, '0, 32'h4));
        s.push_back(idle());                                     exp_q.push_back(ob(0, 0, 0, '0, '0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL fp_raw cyc %0d: got %s want %s", k, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_waw();
        stim_t s[$];
        obs_t  got, want;
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 6, 1, 1, 2'd2, 0)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(idle());                                     exp_q.push_back(ob(0, 0, 0, '0, 32'h40));
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 6, 1, 1, 2'd1, 0)); exp_q.push_back(ob(0, 1, 0, '0, 32'h40));
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 6, 1, 1, 2'd1, 0)); exp_q.push_back(ob(1, 0, 0, '0, 32'h40));
        s.push_back(idle());                                     exp_q.push_back(ob(0, 0, 0, '0, 32'h40));
        s.push_back(idle());                                     exp_q.push_back(ob(0, 0, 0, '0, '0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL waw cyc %0d: got %s want %s", k, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_kill();
        stim_t s[$];
        obs_t  got, want;
        // branch kills two slots; killed load and killed raw leave no trace
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 10, 1, 1, 2'd2, 0)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'd0, 1));  exp_q.push_back(ob(1, 0, 0, '0, 32'h400));
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 9, 0, 1, 2'd1, 0));  exp_q.push_back(ob(0, 0, 1, '0, 32'h400));
        s.push_back(mk(1, 10, 1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 1)); exp_q.push_back(ob(0, 0, 1, '0, 32'h400));
        s.push_back(idle());                                      exp_q.push_back(ob(0, 0, 0, '0, '0));
        // a stalled branch opens its kill window only once accepted
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 11, 1, 1, 2'd2, 0)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(mk(1, 11, 1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 1)); exp_q.push_back(ob(0, 1, 0, '0, 32'h800));
        s.push_back(mk(1, 11, 1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 1)); exp_q.push_back(ob(0, 1, 0, '0, 32'h800));
        s.push_back(mk(1, 11, 1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 1)); exp_q.push_back(ob(0, 1, 0, '0, 32'h800));
        s.push_back(mk(1, 11, 1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 1)); exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(idle());                                      exp_q.push_back(ob(0, 0, 1, '0, '0));
        s.push_back(idle());                                      exp_q.push_back(ob(0, 0, 1, '0, '0));
        s.push_back(idle());                                      exp_q.push_back(ob(0, 0, 0, '0, '0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL kill cyc %0d: got %s want %s", k, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r0_and_mid_reset();
        stim_t s[$];
        obs_t  got, want;
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'd1, 0));           exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(mk(1, 0, 1, 0, 1, 2'b00, 5, 0, 1, 2'd0, 0));           exp_q.push_back(ob(1, 0, 0, '0, '0));
        // FP op to f1 that is also a taken branch, then reset mid-flight
        s.push_back(mk(1, 0, 0, 0, 0, 2'b00, 1, 1, 1, 2'd2, 1));           exp_q.push_back(ob(1, 0, 0, '0, '0));
        s.push_back(with_rst(mk(1, 1, 1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 0))); exp_q.push_back(ob(0, 0, 1, '0, 32'h2));
        s.push_back(mk(1, 1, 1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 0));           exp_q.push_back(ob(1, 0, 0, '0, '0));
        for (int k = 0; k < s.size(); k++) begin
            apply(s[k]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL r0_reset cyc %0d: got %s want %s", k, fmt(got), fmt(want));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_fp_raw();
        test_waw();
        test_kill();
        test_r0_and_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
